// File: rtl/cache_types_pkg.sv
// rtl/cache_types_pkg.sv - shared state encoding and default geometry for inst_line_adapter
package cache_types;

    localparam int DEF_LINE_SIZE  = 256;
    localparam int DEF_BEAT_WIDTH = 64;
    localparam int BEATS          = DEF_LINE_SIZE / DEF_BEAT_WIDTH;
    localparam int OFFSET_BITS    = $clog2(DEF_LINE_SIZE / 8);

    // PF_REQ/PF_BURST are only reached with next-line prefetch compiled in
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        BURST,
        RESP,
        PF_REQ,
        PF_BURST
    } adapter_state_t;

endpackage

// File: rtl/inst_line_adapter_line_assembler.sv
// rtl/inst_line_adapter_line_assembler.sv - beat counter and slot register building one cache line
module line_assembler #(
    parameter int BEAT_WIDTH = 64,
    parameter int BEATS      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        beat_valid,
    input  logic [BEAT_WIDTH-1:0]       beat_data,
    output logic [BEATS*BEAT_WIDTH-1:0] line,
    output logic                        last_beat
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    logic [CW-1:0]         cnt;
    logic [BEAT_WIDTH-1:0] slot [BEATS];

    assign last_beat = beat_valid && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            for (int i = 0; i < BEATS; i++) slot[i] <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (beat_valid) begin
            for (int i = 0; i < BEATS; i++) begin
                if (cnt == CW'(i)) slot[i] <= beat_data;
            end
            cnt <= last_beat ? '0 : cnt + 1'b1;
        end
    end

    // The arriving beat is merged in so the final beat is usable in its own cycle
    always_comb begin
        line = '0;
        for (int i = 0; i < BEATS; i++) begin
            line[i*BEAT_WIDTH +: BEAT_WIDTH] =
                (beat_valid && !clear && cnt == CW'(i)) ? beat_data : slot[i];
        end
    end

endmodule

// File: rtl/inst_line_adapter.sv
// rtl/inst_line_adapter.sv - burst line-fill adapter for the I-cache; optional INST_NEXT_LINE_PREFETCH_EN
module inst_line_adapter
    import cache_types::*;
#(
    parameter int CACHE_LINE_SIZE = 256,
    parameter int BEAT_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_read,
    input  logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic                       mem_resp,
    output logic [CACHE_LINE_SIZE-1:0] mem_line,
    output logic [ADDR_WIDTH-1:0]      bmem_addr,
    output logic                       bmem_read,
    input  logic                       bmem_ready,
    input  logic [BEAT_WIDTH-1:0]      bmem_rdata,
    input  logic                       bmem_rvalid,
    output logic                       busy
);

    localparam int NUM_BEATS = CACHE_LINE_SIZE / BEAT_WIDTH;
    localparam int LINE_OFF  = $clog2(CACHE_LINE_SIZE / 8);
    localparam logic [ADDR_WIDTH-1:0] LINE_BYTES = ADDR_WIDTH'(CACHE_LINE_SIZE / 8);

    adapter_state_t state, state_next;

    logic [ADDR_WIDTH-1:0]      req_line;
    logic [CACHE_LINE_SIZE-1:0] asm_line;
    logic                       asm_last;
    logic                       unused_addr_bits;

    assign req_line         = {mem_addr[ADDR_WIDTH-1:LINE_OFF], {LINE_OFF{1'b0}}};
    assign unused_addr_bits = ^mem_addr[LINE_OFF-1:0];
    assign busy             = (state != IDLE);

    line_assembler #(
        .BEAT_WIDTH (BEAT_WIDTH),
        .BEATS      (NUM_BEATS)
    ) u_demand_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == IDLE),
        .beat_valid (bmem_rvalid && state == BURST),
        .beat_data  (bmem_rdata),
        .line       (asm_line),
        .last_beat  (asm_last)
    );

`ifdef INST_NEXT_LINE_PREFETCH_EN
    logic [CACHE_LINE_SIZE-1:0] pf_buf;
    logic                       pf_last;
    logic                       pf_valid;
    logic [ADDR_WIDTH-1:0]      pf_addr;
    logic                       pend;
    logic [ADDR_WIDTH-1:0]      pend_addr;
    logic                       dem_req;
    logic [ADDR_WIDTH-1:0]      dem_addr;
    logic                       pf_hit;

    line_assembler #(
        .BEAT_WIDTH (BEAT_WIDTH),
        .BEATS      (NUM_BEATS)
    ) u_pf_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == IDLE),
        .beat_valid (bmem_rvalid && state == PF_BURST),
        .beat_data  (bmem_rdata),
        .line       (pf_buf),
        .last_beat  (pf_last)
    );

    // A request parked during prefetch is served from IDLE like a fresh one
    assign dem_req  = mem_read || pend;
    assign dem_addr = pend ? pend_addr : req_line;
    assign pf_hit   = dem_req && pf_valid && (pf_addr == dem_addr);
`endif

    always_comb begin
        state_next = state;
        case (state)
`ifdef INST_NEXT_LINE_PREFETCH_EN
            IDLE:     if (pf_hit) state_next = RESP;
                      else if (dem_req) state_next = REQ;
            RESP:     state_next = PF_REQ;
            PF_REQ:   if (bmem_ready) state_next = PF_BURST;
            PF_BURST: if (pf_last) state_next = IDLE;
`else
            IDLE:     if (mem_read) state_next = REQ;
            RESP:     state_next = IDLE;
`endif
            REQ:      if (bmem_ready) state_next = BURST;
            BURST:    if (asm_last) state_next = RESP;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_resp  <= 1'b0;
            mem_line  <= '0;
            bmem_read <= 1'b0;
            bmem_addr <= '0;
`ifdef INST_NEXT_LINE_PREFETCH_EN
            pf_valid  <= 1'b0;
            pf_addr   <= '0;
            pend      <= 1'b0;
            pend_addr <= '0;
`endif
        end else begin
            state    <= state_next;
            mem_resp <= 1'b0;
            case (state)
`ifdef INST_NEXT_LINE_PREFETCH_EN
                IDLE: begin
                    if (pf_hit) begin
                        mem_resp  <= 1'b1;
                        mem_line  <= pf_buf;
                        pf_valid  <= 1'b0;
                        bmem_addr <= dem_addr;
                        pend      <= 1'b0;
                    end else if (dem_req) begin
                        pf_valid  <= 1'b0;
                        bmem_addr <= dem_addr;
                        bmem_read <= 1'b1;
                        pend      <= 1'b0;
                    end
                end
                RESP: begin
                    bmem_addr <= bmem_addr + LINE_BYTES;
                    bmem_read <= 1'b1;
                end
                PF_REQ: begin
                    if (bmem_ready) bmem_read <= 1'b0;
                    if (mem_read && !pend) begin
                        pend      <= 1'b1;
                        pend_addr <= req_line;
                    end
                end
                PF_BURST: begin
                    if (pf_last) begin
                        pf_valid <= 1'b1;
                        pf_addr  <= bmem_addr;
                    end
                    if (mem_read && !pend) begin
                        pend      <= 1'b1;
                        pend_addr <= req_line;
                    end
                end
`else
                IDLE: begin
                    if (mem_read) begin
                        bmem_addr <= req_line;
                        bmem_read <= 1'b1;
                    end
                end
`endif
                REQ: begin
                    if (bmem_ready) bmem_read <= 1'b0;
                end
                BURST: begin
                    if (asm_last) begin
                        mem_resp <= 1'b1;
                        mem_line <= asm_line;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_line_adapter.sv
// tb/tb_inst_line_adapter.sv - table-driven self-checking bench for inst_line_adapter
module tb_inst_line_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read;
    logic [31:0]  mem_addr;
    logic         mem_resp;
    logic [255:0] mem_line;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_ready;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]  addr;
        logic [63:0]  beat [4];
        int           rdelay;
        int           gap;
        logic [31:0]  exp_addr;
        logic [255:0] exp_line;
    } vec_t;

    vec_t vecs [5];

    inst_line_adapter dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read),
        .mem_addr    (mem_addr),
        .mem_resp    (mem_resp),
        .mem_line    (mem_line),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_ready  (bmem_ready),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [63:0] b0, input logic [63:0] b1,
                                input logic [63:0] b2, input logic [63:0] b3, input int rd,
                                input int gp, input logic [31:0] ea, input logic [255:0] el);
        vec_t v;
        v.addr = a;
        v.beat[0] = b0; v.beat[1] = b1; v.beat[2] = b2; v.beat[3] = b3;
        v.rdelay = rd; v.gap = gp; v.exp_addr = ea; v.exp_line = el;
        return v;
    endfunction

    // Drives one complete fill; mem_read is issued in the current cycle
    task automatic run_fill(input vec_t v, input string tag);
        int lat;
        mem_read = 1'b1;
        mem_addr = v.addr;
        step();
        lat = 1;
        mem_read = 1'b0;
        chk({tag, " req_read"}, 256'(bmem_read), 256'(1));
        chk({tag, " req_addr"}, 256'(bmem_addr), 256'(v.exp_addr));
        for (int i = 0; i < v.rdelay; i++) begin
            bmem_ready = 1'b0;
            step();
            lat++;
            chk({tag, " read_held"}, 256'({bmem_read, bmem_addr}), 256'({1'b1, v.exp_addr}));
        end
        bmem_ready = 1'b1;
        step();
        lat++;
        bmem_ready = 1'b0;
        chk({tag, " read_dropped"}, 256'(bmem_read), 256'(0));
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                for (int g = 0; g < v.gap; g++) begin
                    bmem_rvalid = 1'b0;
                    step();
                    lat++;
                    chk({tag, " no_early_resp"}, 256'(mem_resp), 256'(0));
                end
            end
            bmem_rvalid = 1'b1;
            bmem_rdata  = v.beat[b];
            step();
            lat++;
            bmem_rvalid = 1'b0;
            bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        end
        chk({tag, " resp"}, 256'(mem_resp), 256'(1));
        chk({tag, " latency"}, 256'(lat), 256'(6 + v.rdelay + v.gap));
        chk({tag, " line"}, mem_line, v.exp_line);
        step();
        chk({tag, " resp_one_cycle"}, 256'({mem_resp, busy}), 256'(0));
        chk({tag, " line_hold"}, mem_line, v.exp_line);
    endtask

    initial begin
        vecs[0] = mk(32'h0000_1234, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                     64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 0, 0, 32'h0000_1220,
                     256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
        vecs[1] = mk(32'h0000_ABCD, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A, 3, 2, 32'h0000_ABC0,
                     256'h5A5A5A5A5A5A5A5A_A5A5A5A5A5A5A5A5_FEDCBA9876543210_0123456789ABCDEF);
        vecs[2] = mk(32'hFFFF_FFE0, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0002,
                     64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0004, 1, 1, 32'hFFFF_FFE0,
                     256'hDEADBEEF00000004_DEADBEEF00000003_DEADBEEF00000002_DEADBEEF00000001);
        vecs[3] = mk(32'hFFFF_FFFF, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 0, 3, 32'hFFFF_FFE0,
                     256'h0000000000000000_FFFFFFFFFFFFFFFF_0000000000000001_8000000000000000);
        vecs[4] = mk(32'h0000_301F, 64'hAAAA_0000_0000_0000, 64'hBBBB_0000_0000_0000,
                     64'hCCCC_0000_0000_0000, 64'hDDDD_0000_0000_0000, 0, 0, 32'h0000_3000,
                     256'hDDDD000000000000_CCCC000000000000_BBBB000000000000_AAAA000000000000);

        rst = 1'b1; mem_read = 1'b0; mem_addr = '0;
        bmem_ready = 1'b0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step();
            chk("reset_idle", 256'({mem_resp, bmem_read, busy}), 256'(0));
            chk("reset_line", mem_line, 256'(0));
        end
        chk("reset_addr", 256'(bmem_addr), 256'(0));

        for (int i = 0; i < 4; i++) run_fill(vecs[i], $sformatf("vec%0d", i));

        // Spurious mem_read during BURST must not redirect or restart anything
        mem_read = 1'b1; mem_addr = 32'h0000_4000;
        step();
        mem_read = 1'b0; bmem_ready = 1'b1;
        step();
        bmem_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = 64'(b + 1);
            mem_read    = (b == 0);
            mem_addr    = 32'h0000_8000;
            step();
            mem_read = 1'b0;
            chk("spur_addr", 256'(bmem_addr), 256'h4000);
        end
        bmem_rvalid = 1'b0;
        chk("spur_resp", 256'(mem_resp), 256'(1));
        chk("spur_line", mem_line,
            256'h0000000000000004_0000000000000003_0000000000000002_0000000000000001);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("spur_no_restart", 256'({mem_resp, bmem_read, busy}), 256'(0));
        end

        // rvalid while IDLE is ignored
        for (int i = 0; i < 3; i++) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = 64'hFFFF_0000_FFFF_0000;
            step();
            chk("idle_rvalid_state", 256'({mem_resp, bmem_read, busy}), 256'(0));
        end
        bmem_rvalid = 1'b0;
        chk("idle_rvalid_line", mem_line,
            256'h0000000000000004_0000000000000003_0000000000000002_0000000000000001);

        // Reset after two beats abandons the burst
        mem_read = 1'b1; mem_addr = 32'h0000_3000;
        step();
        mem_read = 1'b0; bmem_ready = 1'b1;
        step();
        bmem_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = 64'hEEEE_EEEE_0000_0000 | 64'(b);
            step();
        end
        bmem_rvalid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_state", 256'({mem_resp, bmem_read, busy}), 256'(0));
        chk("midrst_line", mem_line, 256'(0));
        chk("midrst_addr", 256'(bmem_addr), 256'(0));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst_no_resp", 256'(mem_resp), 256'(0));
        end
        run_fill(vecs[4], "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
